// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: carries IF-stage BTB predictions through ID into EX,
// checks them against the actual outcome, and issues flush/redirect on a
// mispredict. It also produces the BTB update strobe.
// Optional feature: define BRU_PERF_CNT_EN to build the saturating
// branch/mispredict performance counters. When it is undefined, both
// counter outputs are tied to zero.
module branch_resolve_unit #(
    parameter int unsigned PC_WIDTH       = 32,
    parameter int unsigned CNT_WIDTH      = 32,
    parameter int unsigned RECOVER_CYCLES = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [PC_WIDTH-1:0]  pc_IF_i,
    input  logic                 br_sel_BTB_i,
    input  logic [PC_WIDTH-1:0]  pc_BTB_i,
    input  logic                 stall_i,
    input  logic [PC_WIDTH-1:0]  pc_EX_i,
    input  logic [31:0]          instr_EX_i,
    input  logic                 taken_i,
    input  logic [PC_WIDTH-1:0]  alu_data_i,
    output logic                 flush_o,
    output logic                 redirect_o,
    output logic [PC_WIDTH-1:0]  redirect_pc_o,
    output logic                 upd_valid_o,
    output logic                 upd_taken_o,
    output logic                 recover_o,
    output logic [CNT_WIDTH-1:0] branch_cnt_o,
    output logic [CNT_WIDTH-1:0] mispredict_cnt_o
);

    typedef enum logic [0:0] {StIdle, StRecover} state_t;

    localparam logic [2:0] RecLoad = 3'(RECOVER_CYCLES);

    state_t              state, state_next;
    logic [2:0]          rec_cnt, rec_cnt_next;

    // Shadow slots: prediction travelling with the instruction in ID and EX.
    logic                sid_valid, sid_pred;
    logic [PC_WIDTH-1:0] sid_pred_pc, sid_pc;
    logic                sex_valid, sex_pred;
    logic [PC_WIDTH-1:0] sex_pred_pc, sex_pc;

    logic                is_cf, eff_pred, active;
    logic                miss_target, miss_not_taken, miss_alias, mispredict;
    logic [PC_WIDTH-1:0] fallthrough_pc;

    // Only the major opcode field is decoded.
    logic unused_instr;
    assign unused_instr = ^{instr_EX_i[31:7], instr_EX_i[1:0]};

    assign is_cf = (instr_EX_i[6:2] == 5'b11000) || (instr_EX_i[6:2] == 5'b11011) ||
                   (instr_EX_i[6:2] == 5'b11001);
    // A stale or mismatched slot is treated as a not-taken prediction.
    assign eff_pred       = sex_valid && (sex_pc == pc_EX_i) && sex_pred;
    assign active         = !stall_i && (state == StIdle);
    assign fallthrough_pc = pc_EX_i + PC_WIDTH'(4);

    assign miss_target    = is_cf && taken_i && (!eff_pred || (sex_pred_pc != alu_data_i));
    assign miss_not_taken = is_cf && !taken_i && eff_pred;
    assign miss_alias     = !is_cf && eff_pred;
    assign mispredict     = active && (miss_target || miss_not_taken || miss_alias);

    assign flush_o       = mispredict;
    assign redirect_o    = mispredict;
    assign redirect_pc_o = !mispredict ? '0 : (miss_target ? alu_data_i : fallthrough_pc);
    assign upd_valid_o   = is_cf && active;
    assign upd_taken_o   = upd_valid_o && taken_i;
    assign recover_o     = (state == StRecover);

    // Shadow slot pipeline; flush squashes both slots ahead of advance/stall.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sid_valid   <= 1'b0;
            sid_pred    <= 1'b0;
            sid_pred_pc <= '0;
            sid_pc      <= '0;
            sex_valid   <= 1'b0;
            sex_pred    <= 1'b0;
            sex_pred_pc <= '0;
            sex_pc      <= '0;
        end else if (flush_o) begin
            sid_valid <= 1'b0;
            sex_valid <= 1'b0;
        end else if (!stall_i) begin
            sex_valid   <= sid_valid;
            sex_pred    <= sid_pred;
            sex_pred_pc <= sid_pred_pc;
            sex_pc      <= sid_pc;
            sid_valid   <= 1'b1;
            sid_pred    <= br_sel_BTB_i;
            sid_pred_pc <= pc_BTB_i;
            sid_pc      <= pc_IF_i;
        end
    end

    // Recovery FSM state and countdown register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= StIdle;
            rec_cnt <= 3'd0;
        end else begin
            state   <= state_next;
            rec_cnt <= rec_cnt_next;
        end
    end

    // Recovery FSM next state: countdown only advances on unstalled cycles.
    always_comb begin
        state_next   = state;
        rec_cnt_next = rec_cnt;
        unique case (state)
            StIdle: begin
                if (mispredict) begin
                    state_next   = StRecover;
                    rec_cnt_next = RecLoad;
                end
            end
            StRecover: begin
                if (!stall_i) begin
                    if (rec_cnt <= 3'd1) begin
                        state_next   = StIdle;
                        rec_cnt_next = 3'd0;
                    end else begin
                        rec_cnt_next = rec_cnt - 3'd1;
                    end
                end
            end
            default: begin
                state_next   = StIdle;
                rec_cnt_next = 3'd0;
            end
        endcase
    end

`ifdef BRU_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] branch_cnt, mispredict_cnt;

    // Saturating performance counters.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            branch_cnt     <= '0;
            mispredict_cnt <= '0;
        end else begin
            if (upd_valid_o && (branch_cnt != '1)) begin
                branch_cnt <= branch_cnt + CNT_WIDTH'(1);
            end
            if (flush_o && (mispredict_cnt != '1)) begin
                mispredict_cnt <= mispredict_cnt + CNT_WIDTH'(1);
            end
        end
    end

    assign branch_cnt_o     = branch_cnt;
    assign mispredict_cnt_o = mispredict_cnt;
`else
    assign branch_cnt_o     = '0;
    assign mispredict_cnt_o = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed testbench for branch_resolve_unit with hand-computed expectations.
module tb_branch_resolve_unit;

    localparam int unsigned PW = 32;
    localparam int unsigned CW = 32;
`ifdef BRU_PERF_CNT_EN
    localparam bit Perf = 1'b1;
`else
    localparam bit Perf = 1'b0;
`endif

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] BEQ  = 32'h0000_0063;
    localparam logic [31:0] BNE  = 32'h0000_1063;
    localparam logic [31:0] JAL  = 32'h0000_006f;
    localparam logic [31:0] JALR = 32'h0000_8067;
    localparam logic [31:0] ADD  = 32'h0000_0033;

    logic          clk = 1'b0;
    logic          rst;
    logic [PW-1:0] pc_if, pc_btb, pc_ex, alu_data;
    logic          br_sel, stall, taken;
    logic [31:0]   instr_ex;
    logic          flush, redirect, upd_valid, upd_taken, recover;
    logic [PW-1:0] redirect_pc;
    logic [CW-1:0] branch_cnt, mispredict_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_resolve_unit #(
        .PC_WIDTH      (PW),
        .CNT_WIDTH     (CW),
        .RECOVER_CYCLES(2)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .pc_IF_i         (pc_if),
        .br_sel_BTB_i    (br_sel),
        .pc_BTB_i        (pc_btb),
        .stall_i         (stall),
        .pc_EX_i         (pc_ex),
        .instr_EX_i      (instr_ex),
        .taken_i         (taken),
        .alu_data_i      (alu_data),
        .flush_o         (flush),
        .redirect_o      (redirect),
        .redirect_pc_o   (redirect_pc),
        .upd_valid_o     (upd_valid),
        .upd_taken_o     (upd_taken),
        .recover_o       (recover),
        .branch_cnt_o    (branch_cnt),
        .mispredict_cnt_o(mispredict_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_if(input logic [PW-1:0] pc, input logic sel, input logic [PW-1:0] tgt);
        pc_if  = pc;
        br_sel = sel;
        pc_btb = tgt;
    endtask

    task automatic set_ex(input logic [PW-1:0] pc, input logic [31:0] ins, input logic tk,
                          input logic [PW-1:0] alu);
        pc_ex    = pc;
        instr_ex = ins;
        taken    = tk;
        alu_data = alu;
    endtask

    initial begin
        rst   = 1'b1;
        stall = 1'b0;
        set_if('0, 1'b0, '0);
        set_ex('0, NOP, 1'b0, '0);
        tick();
        tick();
        #1;
        check("rst_flush", 64'(flush), 64'd0);
        check("rst_redirect", 64'(redirect), 64'd0);
        check("rst_recover", 64'(recover), 64'd0);
        check("rst_upd_valid", 64'(upd_valid), 64'd0);
        check("rst_bcnt", 64'(branch_cnt), 64'd0);
        check("rst_mcnt", 64'(mispredict_cnt), 64'd0);
        rst = 1'b0;

        // Correct-taken BEQ at 0x100 -> 0x140
        tick();
        set_if(32'h100, 1'b1, 32'h140);
        tick();
        set_if(32'h104, 1'b0, '0);
        tick();
        set_if(32'h108, 1'b0, '0);
        set_ex(32'h100, BEQ, 1'b1, 32'h140);
        #1;
        check("ct_flush", 64'(flush), 64'd0);
        check("ct_redirect_pc", 64'(redirect_pc), 64'd0);
        check("ct_upd_valid", 64'(upd_valid), 64'd1);
        check("ct_upd_taken", 64'(upd_taken), 64'd1);
        tick();
        set_ex('0, NOP, 1'b0, '0);
        #1;
        check("ct_bcnt", 64'(branch_cnt), Perf ? 64'd1 : 64'd0);

        // BNE at 0x200 predicted taken, actually not taken
        set_if(32'h200, 1'b1, 32'h240);
        tick();
        set_if(32'h204, 1'b0, '0);
        tick();
        set_ex(32'h200, BNE, 1'b0, '0);
        #1;
        check("nt_flush", 64'(flush), 64'd1);
        check("nt_redirect", 64'(redirect), 64'd1);
        check("nt_redirect_pc", 64'(redirect_pc), 64'h204);
        check("nt_upd_valid", 64'(upd_valid), 64'd1);
        check("nt_upd_taken", 64'(upd_taken), 64'd0);
        tick();
        set_ex('0, NOP, 1'b0, '0);
        #1;
        check("nt_flush_once", 64'(flush), 64'd0);
        check("nt_recover1", 64'(recover), 64'd1);
        check("nt_mcnt", 64'(mispredict_cnt), Perf ? 64'd1 : 64'd0);
        check("nt_bcnt", 64'(branch_cnt), Perf ? 64'd2 : 64'd0);
        tick();
        check("nt_recover2", 64'(recover), 64'd1);
        tick();
        check("nt_recover_end", 64'(recover), 64'd0);

        // JALR at 0x300 predicted 0x400, actual 0x480; younger 0x304 squashed
        set_if(32'h300, 1'b1, 32'h400);
        tick();
        set_if(32'h304, 1'b1, 32'h380);
        tick();
        set_if(32'h308, 1'b0, '0);
        set_ex(32'h300, JALR, 1'b1, 32'h480);
        #1;
        check("wt_flush", 64'(flush), 64'd1);
        check("wt_redirect_pc", 64'(redirect_pc), 64'h480);
        tick();
        set_if(32'h480, 1'b0, '0);
        set_ex(32'h304, JAL, 1'b1, 32'h999);
        #1;
        check("wt_squash_upd1", 64'(upd_valid), 64'd0);
        check("wt_squash_flush1", 64'(flush), 64'd0);
        tick();
        check("wt_squash_upd2", 64'(upd_valid), 64'd0);
        check("wt_squash_flush2", 64'(flush), 64'd0);
        tick();
        set_ex('0, NOP, 1'b0, '0);
        #1;
        check("wt_idle", 64'(recover), 64'd0);
        check("wt_idle_flush", 64'(flush), 64'd0);

        // ADD at 0x500 aliasing a taken BTB entry
        set_if(32'h500, 1'b1, 32'h600);
        tick();
        set_if(32'h504, 1'b0, '0);
        tick();
        set_ex(32'h500, ADD, 1'b0, '0);
        #1;
        check("al_flush", 64'(flush), 64'd1);
        check("al_redirect_pc", 64'(redirect_pc), 64'h504);
        check("al_upd_valid", 64'(upd_valid), 64'd0);
        tick();
        set_ex('0, NOP, 1'b0, '0);
        tick();
        tick();
        check("al_idle", 64'(recover), 64'd0);

        // PC mismatch: slot predicted taken for 0xA00 but EX holds 0xA08
        set_if(32'hA00, 1'b1, 32'hB00);
        tick();
        set_if(32'hA04, 1'b0, '0);
        tick();
        set_ex(32'hA08, BEQ, 1'b0, '0);
        #1;
        check("pm_flush", 64'(flush), 64'd0);
        check("pm_upd_valid", 64'(upd_valid), 64'd1);
        tick();
        set_ex('0, NOP, 1'b0, '0);

        // Fall-through wraps modulo 2^PC_WIDTH
        set_if(32'hFFFF_FFFC, 1'b1, 32'h10);
        tick();
        set_if(32'h0, 1'b0, '0);
        tick();
        set_ex(32'hFFFF_FFFC, NOP, 1'b0, '0);
        #1;
        check("wr_flush", 64'(flush), 64'd1);
        check("wr_redirect_pc", 64'(redirect_pc), 64'd0);
        tick();
        set_ex('0, NOP, 1'b0, '0);
        tick();
        tick();

        // Stall with a mispredicting BNE at 0x600 in EX
        set_if(32'h600, 1'b1, 32'h700);
        tick();
        set_if(32'h604, 1'b0, '0);
        tick();
        set_ex(32'h600, BNE, 1'b0, '0);
        stall = 1'b1;
        #1;
        check("st_flush0", 64'(flush), 64'd0);
        check("st_upd0", 64'(upd_valid), 64'd0);
        tick();
        check("st_flush1", 64'(flush), 64'd0);
        tick();
        check("st_flush2", 64'(flush), 64'd0);
        tick();
        stall = 1'b0;
        #1;
        check("st_flush_rel", 64'(flush), 64'd1);
        check("st_redirect_pc", 64'(redirect_pc), 64'h604);
        tick();
        set_ex('0, NOP, 1'b0, '0);
        stall = 1'b1;
        #1;
        check("st_rec_stalled", 64'(recover), 64'd1);
        tick();
        stall = 1'b0;
        #1;
        check("st_rec_held", 64'(recover), 64'd1);
        tick();
        check("st_rec_last", 64'(recover), 64'd1);
        tick();
        check("st_rec_done", 64'(recover), 64'd0);

        // Reset one cycle into RECOVER
        set_ex(32'h700, JAL, 1'b1, 32'h800);
        #1;
        check("rr_flush", 64'(flush), 64'd1);
        tick();
        set_ex('0, NOP, 1'b0, '0);
        #1;
        check("rr_recover", 64'(recover), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("rr_recover_clr", 64'(recover), 64'd0);
        check("rr_flush_clr", 64'(flush), 64'd0);
        check("rr_bcnt", 64'(branch_cnt), 64'd0);
        check("rr_mcnt", 64'(mispredict_cnt), 64'd0);
        set_if(32'h900, 1'b1, 32'h940);
        tick();
        set_if(32'h904, 1'b0, '0);
        tick();
        set_ex(32'h900, BEQ, 1'b1, 32'h940);
        #1;
        check("rr_ct_flush", 64'(flush), 64'd0);
        check("rr_ct_upd_valid", 64'(upd_valid), 64'd1);
        check("rr_ct_upd_taken", 64'(upd_taken), 64'd1);
        tick();
        set_ex('0, NOP, 1'b0, '0);
        #1;
        check("rr_ct_bcnt", 64'(branch_cnt), Perf ? 64'd1 : 64'd0);
        check("rr_ct_mcnt", 64'(mispredict_cnt), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
